// File: rtl/mem_pkg.sv
// Shared encodings for the wait-state data memory.
//   op_e    : request operation codes (load/store/swap/reserved)
//   size_e  : access size codes (byte/half/word/reserved)
//   state_e : FSM state encoding for data_memory_ws
//   misaligned() : alignment check of an access given size and addr[1:0]
package mem_pkg;

    typedef enum logic [1:0] {
        OpLoad  = 2'b00,
        OpStore = 2'b01,
        OpSwap  = 2'b10,
        OpRsvd  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10,
        SzRsvd = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam int unsigned CntW = 4;

    // True when the access does not sit on its natural boundary.
    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (sz)
            SzHalf:  bad = lo[0];
            SzWord:  bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational lane handling for sub-word accesses.
//   word_i     : current contents of the addressed word
//   lane_i     : addr[1:0] of the access
//   size_i     : access size
//   unsigned_i : zero-extend (1) or sign-extend (0) sub-word loads
//   wdata_i    : right-aligned store data
//   load_o     : addressed lane extracted and extended (word passes through)
//   merge_o    : word_i with the addressed lane replaced by the low bits of wdata_i
module lane_align
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      lane_i,
    input  size_e           size_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{lane_i, 3'b000} +: 8];
        half_v = word_i[{lane_i[1], 4'b0000} +: 16];
        load_o = '0;
        case (size_i)
            SzByte: load_o = unsigned_i ? {{(XLEN-8){1'b0}}, byte_v}
                                        : {{(XLEN-8){byte_v[7]}}, byte_v};
            SzHalf: load_o = unsigned_i ? {{(XLEN-16){1'b0}}, half_v}
                                        : {{(XLEN-16){half_v[15]}}, half_v};
            SzWord: load_o = word_i;
            default: load_o = '0;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        case (size_i)
            SzByte: merge_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
            SzHalf: merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SzWord: merge_o = wdata_i;
            default: merge_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_memory_ws.sv
// Word-organised data memory with a fixed number of wait states per access.
// One request is outstanding at a time: IDLE -> WAIT (WAIT cycles) -> RESP -> IDLE.
//   clk, rst (sync, active-low)
//   req_valid/req_ready     : request handshake, ready only in IDLE
//   req_op/req_size         : operation and size codes (see mem_pkg)
//   req_unsigned            : zero-extend sub-word loads
//   req_addr/req_wdata      : byte address and right-aligned write data
//   resp_valid              : one-cycle response strobe
//   resp_rdata/resp_err     : load/swap old data and reject flag, zero outside RESP
module data_memory_ws
    import mem_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned WAIT       = 2,
    parameter int unsigned INIT_IDENT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int unsigned     IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit              NoWait  = (WAIT == 0);
    localparam logic [CntW-1:0] WaitCnt = CntW'(WAIT);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            commit;

    // Request fields captured at accept.
    op_e             op_q;
    size_e           size_q;
    logic            uns_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic            accept;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (NoWait) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitCnt;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                // Leaving on the last wait cycle; <= also recovers from a zero count.
                if (cnt_q <= CntW'(1)) begin
                    state_d = StResp;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign accept     = (state_q == StIdle) && req_valid;
    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);

    // ---------------- Access path ----------------
    // With no wait states the access commits on the accept edge, so it must use
    // the live request rather than the captured copy.
    op_e             acc_op;
    size_e           acc_size;
    logic            acc_uns;
    logic [XLEN-1:0] acc_addr;
    logic [XLEN-1:0] acc_wdata;
    logic            acc_oob;
    logic            acc_err;
    logic [IdxW-1:0] acc_idx;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] merge_word;
    logic [XLEN-1:0] resp_data;
    logic            we;

    logic [DEPTH-1:0][XLEN-1:0] mem_words;

    always_comb begin
        if (state_q == StIdle) begin
            acc_op    = op_e'(req_op);
            acc_size  = size_e'(req_size);
            acc_uns   = req_unsigned;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_op    = op_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign acc_oob = ({2'b00, acc_addr[XLEN-1:2]} >= XLEN'(DEPTH));
    assign acc_idx = acc_addr[IdxW+1:2];

    assign acc_err = (acc_op == OpRsvd) || (acc_size == SzRsvd) ||
                     misaligned(acc_size, acc_addr[1:0]) ||
                     ((acc_op == OpSwap) && (acc_size != SzWord)) ||
                     acc_oob;

    assign rd_word = acc_oob ? '0 : mem_words[acc_idx];

    lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .word_i    (rd_word),
        .lane_i    (acc_addr[1:0]),
        .size_i    (acc_size),
        .unsigned_i(acc_uns),
        .wdata_i   (acc_wdata),
        .load_o    (load_word),
        .merge_o   (merge_word)
    );

    // Swap is word-only, so the lane path yields the old word and the new word.
    assign resp_data = (acc_err || (acc_op == OpStore)) ? '0 : load_word;
    assign we        = commit && !acc_err && rst &&
                       ((acc_op == OpStore) || (acc_op == OpSwap));

    // ---------------- State registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Response registers are only non-zero for the single RESP cycle.
            if (commit) begin
                rdata_q <= resp_data;
                err_q   <= acc_err;
            end else begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // Captured request needs no reset: it is only read outside IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op_e'(req_op);
            size_q  <= size_e'(req_size);
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // ---------------- Storage ----------------
    // Per-word registers with a power-up value; reset never touches them.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [XLEN-1:0] word_q = (INIT_IDENT != 0) ? XLEN'(i) : '0;

        always_ff @(posedge clk) begin
            if (we && (acc_idx == IdxW'(i))) begin
                word_q <= merge_word;
            end
        end

        assign mem_words[i] = word_q;
    end

endmodule

// File: doc/data_memory_ws.md
DATA_MEMORY_WS -- requirements
Module: data_memory_ws

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 128, number of XLEN-bit words.
REQ-003 SHALL have parameter WAIT, default 2, range 0..15, wait-state cycles per access.
REQ-004 SHALL have parameter INIT_IDENT, default 1; when 1, word i holds value i at time zero.
REQ-005 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port req_valid  in  1  request present.
REQ-008 SHALL have port req_ready  out  1  block can accept a request.
REQ-009 SHALL have port req_op  in  2  00 load, 01 store, 10 swap, 11 reserved.
REQ-010 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 SHALL have port req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-012 SHALL have port req_addr  in  XLEN  byte address.
REQ-013 SHALL have port req_wdata  in  XLEN  store/swap data, right-aligned.
REQ-014 SHALL have port resp_valid  out  1  one-cycle response strobe.
REQ-015 SHALL have port resp_rdata  out  XLEN  load/swap old data, extended.
REQ-016 SHALL have port resp_err  out  1  request rejected, no memory effect.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT skipped when WAIT=0.
REQ-018 SHALL assert req_ready only in IDLE; request accepted on edge where req_valid && req_ready; all req_* fields captured then.
REQ-019 SHALL count exactly WAIT cycles in WAIT state with a 4-bit down-counter loaded at accept.
REQ-020 SHALL perform the memory access on the edge entering RESP; resp_valid high only in RESP, exactly one cycle.
REQ-021 Latency: accept at edge N -> resp_valid high in cycle N+WAIT+1; next accept no earlier than RESP+1; throughput one per WAIT+2 cycles.
REQ-022 Load SHALL return the addressed lane (byte lane addr[1:0], half lane addr[1]) extended per req_unsigned; word returned unchanged.
REQ-023 Store SHALL merge low byte/half/word of req_wdata into the addressed lane only; other lanes unchanged; resp_rdata=0.
REQ-024 Swap SHALL be word-only, atomic: resp_rdata = old word, new word = req_wdata, in the same edge.
REQ-025 SHALL flag resp_err=1, resp_rdata=0, no write, same latency, when: half with addr[0]=1; word/swap with addr[1:0]!=0; swap with size!=word; word index addr[XLEN-1:2] >= DEPTH; req_op=11 or req_size=11.
REQ-026 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-027 req_* changes while not in IDLE SHALL be ignored.

Reset
REQ-028 rst=0 at an edge SHALL force IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 1 from next cycle.
REQ-029 Reset mid-operation SHALL abort the captured request; store/swap not yet at commit edge SHALL NOT write.
REQ-030 Memory array SHALL NOT be cleared by reset.

Structure
REQ-031 Op codes, size codes and FSM state encoding SHALL live in shared package mem_pkg.
REQ-032 Lane extract/extend and lane merge SHALL be one combinational sub-module lane_align.

Verification (XLEN=32, DEPTH=128, WAIT=2, INIT_IDENT=1)
REQ-033 Load word 0x10 after reset -> resp_valid 3 cycles after accept, rdata 0x00000004, err 0.
REQ-034 Store byte 0xAB at 0x21, load word 0x20 -> 0x0000AB08; load byte signed 0x21 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-035 Swap word 0x0C with 0xDEADBEEF -> rdata 0x00000003; following load 0x0C -> 0xDEADBEEF.
REQ-036 Load word 0x22 -> err 1, rdata 0; store word 0x200 -> err 1, no array change; op 11 -> err 1.
REQ-037 req_valid held high continuously with two requests -> req_ready 0 during WAIT/RESP, second accepted in cycle after RESP, both responses present, none lost.
REQ-038 rst low during WAIT of store 0x55 at 0x08 -> no resp_valid, outputs 0; subsequent load 0x08 -> 0x00000002.
